// File: rtl/conv2d_stream_if.sv
// Handshake bundle for conv2d_stream: frame control, weight load,
// pixel input stream and feature output stream.
interface conv2d_stream_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic                  start;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_valid;
    logic [DATA_WIDTH-1:0] pix_in;
    logic                  pix_valid;
    logic                  pix_ready;
    logic [DATA_WIDTH-1:0] feat_out;
    logic                  feat_valid;
    logic                  feat_ready;
    logic                  busy;
    logic                  conv_done;

    // Driver side: pixel source / controller.
    modport master (
        output start, w_data, w_valid, pix_in, pix_valid, feat_ready,
        input  pix_ready, feat_out, feat_valid, busy, conv_done
    );

    // Convolution engine side.
    modport slave (
        input  start, w_data, w_valid, pix_in, pix_valid, feat_ready,
        output pix_ready, feat_out, feat_valid, busy, conv_done
    );
endinterface

// File: rtl/conv2d_stream.sv
// Streaming 3x3 signed fixed-point "valid" convolution with two line
// buffers, per-frame weight/bias load, optional ReLU and saturation.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start
// S_LOAD_W | collecting 9 weights (raster order) then bias
// S_RUN    | accepting pixels, producing one feature per full window
// S_DONE   | one-cycle conv_done pulse, weights discarded
module conv2d_stream #(
    parameter int IMG_HEIGHT = 256,
    parameter int IMG_WIDTH  = 256,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter bit RELU_EN    = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    conv2d_stream_if.slave  bus
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = 2 * DATA_WIDTH + 4;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_RUN, S_DONE} state_t;

    state_t                r_state;
    logic [3:0]            r_widx;
    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic                  r_last_acc;
    logic                  r_busy;
    logic                  r_done;
    logic signed [DW-1:0]  r_w [0:9];
    logic signed [DW-1:0]  r_win [0:2][0:2];
    logic signed [DW-1:0]  r_lb0 [0:IMG_WIDTH-1];   // row-1
    logic signed [DW-1:0]  r_lb1 [0:IMG_WIDTH-1];   // row-2
    logic signed [DW-1:0]  r_feat_out;
    logic                  r_feat_valid;

    logic                  w_pix_ready;
    logic                  w_accept;
    logic                  w_feat_hs;
    logic                  w_win_valid;
    logic                  w_col_last;
    logic                  w_row_last;
    logic signed [DW-1:0]  w_win_next [0:2][0:2];
    logic signed [AW-1:0]  w_acc;
    logic signed [AW-1:0]  w_sum;
    logic signed [AW-1:0]  w_shift;
    logic signed [DW-1:0]  w_result;

    assign w_pix_ready = (r_state == S_RUN) && !r_last_acc && (!r_feat_valid || bus.feat_ready);
    assign w_accept    = bus.pix_valid && w_pix_ready;
    assign w_feat_hs   = r_feat_valid && bus.feat_ready;
    assign w_win_valid = (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_col_last  = (r_col == CW'(IMG_WIDTH - 1));
    assign w_row_last  = (r_row == RW'(IMG_HEIGHT - 1));

    // Window as it will look after the current pixel shifts in; the result
    // is computed from it so the feature lands one cycle after the accept.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_win_next[i][0] = r_win[i][1];
            w_win_next[i][1] = r_win[i][2];
        end
        w_win_next[0][2] = r_lb1[r_col];
        w_win_next[1][2] = r_lb0[r_col];
        w_win_next[2][2] = bus.pix_in;
    end

    // 9-tap MAC plus bias; widths chosen so the sum can never overflow.
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_acc = w_acc + AW'(r_w[i*3+j]) * AW'(w_win_next[i][j]);
            end
        end
        w_sum   = w_acc + (AW'(r_w[9]) <<< FRAC_BITS);
        w_shift = w_sum >>> FRAC_BITS;
    end

    // ReLU then saturation to the output word.
    always_comb begin
        if (RELU_EN && (w_shift < 0)) begin
            w_result = '0;
        end else if (w_shift > SAT_MAX) begin
            w_result = SAT_MAX[DW-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_result = SAT_MIN[DW-1:0];
        end else begin
            w_result = w_shift[DW-1:0];
        end
    end

    // Frame sequencing, weight capture and raster counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_widx     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_last_acc <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            for (int k = 0; k < 10; k++) r_w[k] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state    <= S_LOAD_W;
                        r_widx     <= '0;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_last_acc <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_LOAD_W: begin
                    if (bus.w_valid) begin
                        r_w[r_widx] <= bus.w_data;
                        if (r_widx == 4'd9) begin
                            r_widx  <= '0;
                            r_state <= S_RUN;
                        end else begin
                            r_widx <= r_widx + 4'd1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_col_last) begin
                            r_col <= '0;
                            if (w_row_last) r_last_acc <= 1'b1;
                            else            r_row <= r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                    if (r_last_acc && w_feat_hs) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    for (int k = 0; k < 10; k++) r_w[k] <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output register: a new window result wins over a handshake clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_feat_out   <= '0;
            r_feat_valid <= 1'b0;
        end else if (w_accept && w_win_valid) begin
            r_feat_out   <= w_result;
            r_feat_valid <= 1'b1;
        end else if (w_feat_hs) begin
            r_feat_valid <= 1'b0;
        end
    end

    // Line buffers and window shift, advanced only on an accepted pixel.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= w_win_next[i][j];
                end
            end
            r_lb1[r_col] <= r_lb0[r_col];
            r_lb0[r_col] <= bus.pix_in;
        end
    end

    assign bus.pix_ready  = w_pix_ready;
    assign bus.feat_out   = r_feat_out;
    assign bus.feat_valid = r_feat_valid;
    assign bus.busy       = r_busy;
    assign bus.conv_done  = r_done;
endmodule

// File: tb/tb_conv2d_stream.sv
// Bench for conv2d_stream: two 4x4 instances (ReLU on / off) share one
// stimulus stream; outputs are checked against constant tables and a
// frame-level arithmetic model.
module tb_conv2d_stream;
    localparam int H  = 4;
    localparam int W  = 4;
    localparam int NP = H * W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv2d_stream_if #(.DATA_WIDTH(16)) ifa ();
    conv2d_stream_if #(.DATA_WIDTH(16)) ifb ();

    assign ifb.start      = ifa.start;
    assign ifb.w_data     = ifa.w_data;
    assign ifb.w_valid    = ifa.w_valid;
    assign ifb.pix_in     = ifa.pix_in;
    assign ifb.pix_valid  = ifa.pix_valid;
    assign ifb.feat_ready = ifa.feat_ready;

    conv2d_stream #(.IMG_HEIGHT(H), .IMG_WIDTH(W), .DATA_WIDTH(16), .FRAC_BITS(8), .RELU_EN(1'b1))
        u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    conv2d_stream #(.IMG_HEIGHT(H), .IMG_WIDTH(W), .DATA_WIDTH(16), .FRAC_BITS(8), .RELU_EN(1'b0))
        u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] cur_w [10];
    logic [15:0] cur_pix [NP];
    logic [15:0] qa[$], qb[$], ea[$], eb[$];

    int   nidx = 0;
    int   done_cnt = 0;
    int   done_neg = 0;
    int   last_hs_neg = 0;
    int   stab_err = 0;
    logic prev_hold = 1'b0;
    logic [15:0] prev_val = '0;

    typedef struct {
        logic [15:0] w_all;
        logic [15:0] w_ctr;
        logic [15:0] bias;
        logic [15:0] pix;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;
    vec_t vt [6];

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Output monitor, sampled mid-cycle; each record is a handshake at the next edge.
    always @(negedge clk) begin
        nidx <= nidx + 1;
        if (!rst_n) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold && (!ifa.feat_valid || ifa.feat_out !== prev_val))
                stab_err <= stab_err + 1;
            prev_hold <= ifa.feat_valid && !ifa.feat_ready;
            prev_val  <= ifa.feat_out;
            if (ifa.feat_valid && ifa.feat_ready) begin
                qa.push_back(ifa.feat_out);
                last_hs_neg <= nidx;
            end
            if (ifb.feat_valid && ifb.feat_ready) qb.push_back(ifb.feat_out);
            if (ifa.conv_done) begin
                done_cnt <= done_cnt + 1;
                done_neg <= nidx;
            end
        end
    end

    // Reference: direct valid convolution of the frame, floor shift, ReLU, clamp.
    function automatic logic [15:0] ref_out(input int y, input int x, input bit relu);
        longint acc;
        acc = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                acc += longint'($signed(cur_w[r*3+c])) *
                       longint'($signed(cur_pix[(y-2+r)*W + (x-2+c)]));
        acc += longint'($signed(cur_w[9])) * 256;
        acc = acc >>> 8;
        if (relu && acc < 0) acc = 0;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc[15:0];
    endfunction

    task automatic build_expected();
        ea.delete();
        eb.delete();
        for (int y = 2; y < H; y++)
            for (int x = 2; x < W; x++) begin
                ea.push_back(ref_out(y, x, 1'b1));
                eb.push_back(ref_out(y, x, 1'b0));
            end
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_pix_ready"},  ifa.pix_ready,  0);
        check({p, "_feat_valid"}, ifa.feat_valid, 0);
        check({p, "_feat_out"},   ifa.feat_out,   0);
        check({p, "_busy"},       ifa.busy,       0);
        check({p, "_conv_done"},  ifa.conv_done,  0);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        ifa.start = 0; ifa.w_valid = 0; ifa.pix_valid = 0; ifa.feat_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic start_and_load(input string nm, input bit rnd);
        @(posedge clk); #1 ifa.start = 1;
        @(posedge clk); #1 ifa.start = 0;
        check({nm, "_busy_after_start"}, ifa.busy, 1);
        check({nm, "_pix_ready_in_load"}, ifa.pix_ready, 0);
        for (int k = 0; k < 10; k++) begin
            if (rnd) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) begin @(posedge clk); #1 ifa.w_valid = 0; end
            end
            @(posedge clk); #1;
            ifa.w_valid = 1;
            ifa.w_data  = cur_w[k];
        end
        @(posedge clk); #1 ifa.w_valid = 0;
    endtask

    // One full frame; rnd = random pix_valid / 30% feat_ready, glitch = stray start/w_valid.
    task automatic run_frame(input string nm, input bit rnd, input bit glitch);
        int base, sbase, idx, cyc;
        qa.delete();
        qb.delete();
        build_expected();
        base  = done_cnt;
        sbase = stab_err;
        start_and_load(nm, rnd);
        idx = 0;
        cyc = 0;
        while (done_cnt == base && cyc < 400) begin
            @(posedge clk); #1;
            ifa.pix_valid  = (idx < NP) && (rnd ? ($urandom_range(0, 99) < 70) : 1'b1);
            ifa.pix_in     = (idx < NP) ? cur_pix[idx] : 16'h0;
            ifa.feat_ready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
            if (glitch && idx < NP) begin
                ifa.start   = $urandom_range(0, 1) == 1;
                ifa.w_valid = $urandom_range(0, 1) == 1;
                ifa.w_data  = 16'($urandom);
            end else begin
                ifa.start   = 0;
                ifa.w_valid = 0;
            end
            @(negedge clk);
            if (ifa.pix_valid && ifa.pix_ready) idx++;
            cyc++;
        end
        @(posedge clk); #1;
        ifa.pix_valid = 0; ifa.start = 0; ifa.w_valid = 0; ifa.feat_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check({nm, "_done_pulses"}, done_cnt - base, 1);
        check({nm, "_done_after_last_hs"}, done_neg - last_hs_neg, 1);
        check({nm, "_busy_idle"}, ifa.busy, 0);
        check({nm, "_hold_violations"}, stab_err - sbase, 0);
        check({nm, "_count_a"}, qa.size(), ea.size());
        check({nm, "_count_b"}, qb.size(), eb.size());
        for (int i = 0; i < ea.size() && i < qa.size(); i++)
            check($sformatf("%s_model_a%0d", nm, i), qa[i], ea[i]);
        for (int i = 0; i < eb.size() && i < qb.size(); i++)
            check($sformatf("%s_model_b%0d", nm, i), qb[i], eb[i]);
        if (done_cnt - base != 1) apply_reset();
    endtask

    task automatic set_identity();
        for (int k = 0; k < 10; k++) cur_w[k] = 16'h0;
        cur_w[4] = 16'h0100;
        for (int k = 0; k < NP; k++) cur_pix[k] = 16'(k << 8);
    endtask

    task automatic check_identity(input string nm);
        logic [15:0] exp_id [4];
        exp_id[0] = 16'h0500; exp_id[1] = 16'h0600;
        exp_id[2] = 16'h0900; exp_id[3] = 16'h0A00;
        check({nm, "_id_count"}, qa.size(), 4);
        for (int i = 0; i < 4 && i < qa.size(); i++)
            check($sformatf("%s_id_a%0d", nm, i), qa[i], exp_id[i]);
        for (int i = 0; i < 4 && i < qb.size(); i++)
            check($sformatf("%s_id_b%0d", nm, i), qb[i], exp_id[i]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int idx;
        vt[0] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0A00, 16'h0A00};
        vt[1] = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        vt[2] = '{16'h8000, 16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 16'h8000};
        vt[3] = '{16'h0000, 16'h0000, 16'hFF00, 16'h1234, 16'h0000, 16'hFF00};
        vt[4] = '{16'h0000, 16'h0001, 16'h0000, 16'hFF80, 16'h0000, 16'hFFFF};
        vt[5] = '{16'h0000, 16'h0200, 16'hFF80, 16'h0300, 16'h0580, 16'h0580};

        ifa.start = 0; ifa.w_valid = 0; ifa.w_data = 0;
        ifa.pix_valid = 0; ifa.pix_in = 0; ifa.feat_ready = 1;
        #3;
        check_reset_vals("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        set_identity();
        run_frame("identity", 1'b0, 1'b0);
        check_identity("identity");

        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < 9; k++) cur_w[k] = vt[v].w_all;
            cur_w[4] = vt[v].w_ctr;
            cur_w[9] = vt[v].bias;
            for (int k = 0; k < NP; k++) cur_pix[k] = vt[v].pix;
            run_frame($sformatf("vec%0d", v), 1'b0, 1'b0);
            check($sformatf("vec%0d_count", v), qa.size(), 4);
            for (int i = 0; i < qa.size(); i++)
                check($sformatf("vec%0d_tab_a%0d", v, i), qa[i], vt[v].exp_a);
            for (int i = 0; i < qb.size(); i++)
                check($sformatf("vec%0d_tab_b%0d", v, i), qb[i], vt[v].exp_b);
        end

        set_identity();
        run_frame("identity_bp", 1'b1, 1'b0);
        check_identity("identity_bp");
        run_frame("identity_glitch", 1'b1, 1'b1);
        check_identity("identity_glitch");

        // Reset after 7 accepted pixels, then a clean identity frame.
        set_identity();
        start_and_load("midreset", 1'b0);
        idx = 0;
        for (int c = 0; c < 50 && idx < 7; c++) begin
            @(posedge clk); #1;
            ifa.pix_valid = (idx < 7);
            ifa.pix_in    = cur_pix[idx];
            @(negedge clk);
            if (ifa.pix_valid && ifa.pix_ready) idx++;
        end
        @(posedge clk); #1;
        ifa.pix_valid = 0;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_frame("after_reset", 1'b0, 1'b0);
        check_identity("after_reset");

        // Random frames against the model, alternating flow control.
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 10; k++) cur_w[k] = 16'($urandom_range(0, 1023) - 512);
            if (f >= 4) for (int k = 0; k < 10; k++) cur_w[k] = 16'($urandom);
            for (int k = 0; k < NP; k++) cur_pix[k] = 16'($urandom);
            run_frame($sformatf("rand%0d", f), f[0], f == 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
